adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit carry-skip adder (`C_Skip_Adder_32`) among `NREQ` requesters. Each requester presents operands `a`, `b` and `cin` over a valid/ready handshake. The block grants one request at a time, registers the operands into the adder, captures `sum`/`cout`, and returns a tagged response over a valid/ready handshake. It sits between client datapaths and the shared adder, so only one adder instance is needed.

---
 rtl/adder_arb_pkg.sv | 14 +
 rtl/C_Skip_Adder_32.sv | 41 ++++
 rtl/rr_pick.sv | 34 +++
 rtl/adder_share_arbiter.sv | 135 +++++++++++++
 tb/tb_adder_share_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder sharing arbiter.
// Provides the sequencer state encoding and the datapath/counter widths.
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int ADD_W = 32;
   localparam int CNT_W = 16;

endpackage

// File: rtl/C_Skip_Adder_32.sv
// 32-bit carry-skip adder built from eight 4-bit ripple blocks.
// Ports:
//   a, b  : 32-bit operands
//   cin   : carry-in
//   sum   : 32-bit sum
//   cout  : carry-out
module C_Skip_Adder_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] p;
   logic [31:0] g;
   logic [8:0]  bc;

   assign p = a ^ b;
   assign g = a & b;

   always_comb begin
      logic c;
      sum   = '0;
      bc    = '0;
      c     = 1'b0;
      bc[0] = cin;
      for (int k = 0; k < 8; k++) begin
         c = bc[k];
         for (int j = 0; j < 4; j++) begin
            sum[4*k+j] = p[4*k+j] ^ c;
            c          = g[4*k+j] | (p[4*k+j] & c);
         end
         // When every bit of the block propagates, the block carry-in
         // bypasses the ripple chain.
         bc[k+1] = (&p[4*k +: 4]) ? bc[k] : c;
      end
      cout = bc[8];
   end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_valid : per-requester valid
//   ptr       : index where the search starts (highest priority)
//   grant     : one-hot grant, or zero when nothing is valid
//   winner    : index of the granted requester (0 when nothing is valid)
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  winner
);

   always_comb begin
      int   idx;
      logic found;
      grant  = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
      if (found) grant[winner] = 1'b1;
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit carry-skip adder among
// NREQ requesters. One operation at a time: IDLE (grant) -> EXEC (add) ->
// RESP (hold response until accepted).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; the source holds its payload stable while valid is high.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_ready  : per-requester accept, one-hot or zero (IDLE only)
//   req_a/b    : packed operands, requester i at [32i+31:32i]
//   req_cin    : per-requester carry-in
//   rsp_valid  : response valid (RESP state)
//   rsp_ready  : response accept
//   rsp_id     : owner of the response
//   rsp_sum    : 32-bit sum
//   rsp_cout   : carry-out
//   busy       : high whenever the sequencer is not IDLE
//   op_count   : completed responses, wraps modulo 2^16
module adder_share_arbiter
   import adder_arb_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*ADD_W-1:0] req_a,
   input  logic [NREQ*ADD_W-1:0] req_b,
   input  logic [NREQ-1:0]       req_cin,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [ADD_W-1:0]      rsp_sum,
   output logic                  rsp_cout,
   output logic                  busy,
   output logic [CNT_W-1:0]      op_count
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [NREQ-1:0]  grant;
   logic [IDW-1:0]   winner;
   logic             any_valid;

   logic [ADD_W-1:0] op_a_q, op_b_q;
   logic             op_cin_q;
   logic [IDW-1:0]   op_id_q;

   logic [ADD_W-1:0] add_sum;
   logic             add_cout;

   logic [ADD_W-1:0] rsp_sum_q;
   logic             rsp_cout_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [CNT_W-1:0] op_cnt_q;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_valid (req_valid),
      .ptr       (ptr_q),
      .grant     (grant),
      .winner    (winner)
   );

   // The adder only ever sees the registered operands, so its full carry
   // path is a single register-to-register cycle in EXEC.
   C_Skip_Adder_32 u_add (
      .a    (op_a_q),
      .b    (op_b_q),
      .cin  (op_cin_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   assign any_valid = |req_valid;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_cin_q   <= 1'b0;
         op_id_q    <= '0;
         rsp_sum_q  <= '0;
         rsp_cout_q <= 1'b0;
         rsp_id_q   <= '0;
         op_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  op_a_q   <= req_a[int'(winner)*ADD_W +: ADD_W];
                  op_b_q   <= req_b[int'(winner)*ADD_W +: ADD_W];
                  op_cin_q <= req_cin[winner];
                  op_id_q  <= winner;
                  ptr_q    <= (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);
               end
            end
            EXEC: begin
               rsp_sum_q  <= add_sum;
               rsp_cout_q <= add_cout;
               rsp_id_q   <= op_id_q;
            end
            RESP: begin
               if (rsp_ready) op_cnt_q <= op_cnt_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_id    = rsp_id_q;
   assign op_count  = op_cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*32-1:0] req_a;
   logic [NREQ*32-1:0] req_b;
   logic [NREQ-1:0]   req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [31:0]       rsp_sum;
   logic              rsp_cout;
   logic              busy;
   logic [15:0]       op_count;

   int n_total;
   int n_bad;

   adder_share_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy),
      .op_count  (op_count)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present one request; returns #1 after the accept edge (state EXEC).
   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input string tag);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_a[id*32 +: 32] = a;
      req_b[id*32 +: 32] = b;
      req_cin[id] = c;
      #1;
      check({tag, "_req_ready"}, 64'(req_ready), 64'(1) << id);
      @(posedge clk); #1;
      req_valid = '0;
      check({tag, "_busy_exec"}, 64'(busy), 64'd1);
      check({tag, "_no_rsp_exec"}, 64'(rsp_valid), 64'd0);
   endtask

   // From EXEC: check response at N+2, accept it, check return to IDLE.
   task automatic finish_op(input logic [31:0] es, input logic ec, input int eid,
                            input logic [15:0] ecnt, input string tag);
      @(posedge clk); #1;
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      check({tag, "_rsp_sum"}, 64'(rsp_sum), 64'(es));
      check({tag, "_rsp_cout"}, 64'(rsp_cout), 64'(ec));
      check({tag, "_rsp_id"}, 64'(rsp_id), 64'(eid));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, "_idle_valid"}, 64'(rsp_valid), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_op_count"}, 64'(op_count), 64'(ecnt));
   endtask

   // fairness vectors, hand-computed {cout,sum}
   logic [31:0] fa_a [4];
   logic [31:0] fa_b [4];
   logic [32:0] fa_e [4];

   initial begin
      n_total = 0;
      n_bad   = 0;
      fa_a[0] = 32'h0000_0001; fa_b[0] = 32'hFFFF_FFFF; fa_e[0] = {1'b1, 32'h0000_0000};
      fa_a[1] = 32'hFFFF_FFFF; fa_b[1] = 32'hFFFF_FFFF; fa_e[1] = {1'b1, 32'hFFFF_FFFF};
      fa_a[2] = 32'h8000_0000; fa_b[2] = 32'h8000_0000; fa_e[2] = {1'b1, 32'h0000_0000};
      fa_a[3] = 32'h1234_5678; fa_b[3] = 32'h0000_0000; fa_e[3] = {1'b0, 32'h1234_5679};

      // reset with all requests valid: nothing may be granted
      rst = 1'b1;
      req_valid = '1;
      req_a = '0;
      req_b = '0;
      req_cin = '0;
      rsp_ready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_sum", 64'(rsp_sum), 64'd0);
      check("rst_rsp_cout", 64'(rsp_cout), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      req_valid = '0;
      rst = 1'b0;
      @(posedge clk); #1;

      // single op, requester 2 (ptr 0 -> 3)
      issue(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "single");
      finish_op(32'h0000_0000, 1'b1, 2, 16'd1, "single");

      // carry-in, requester 1 (ptr 3 -> 2)
      issue(1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, "cin");
      finish_op(32'h8000_0000, 1'b0, 1, 16'd2, "cin");

      // backpressure, requester 3 (ptr 2 -> 0)
      issue(3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "bp");
      @(posedge clk); #1;
      req_valid = 4'b0110;
      #1;
      for (int k = 0; k < 5; k++) begin
         check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         check("bp_rsp_sum", 64'(rsp_sum), 64'hACF1_3569);
         check("bp_rsp_cout", 64'(rsp_cout), 64'd0);
         check("bp_rsp_id", 64'(rsp_id), 64'd3);
         check("bp_req_ready", 64'(req_ready), 64'd0);
         check("bp_busy", 64'(busy), 64'd1);
         @(posedge clk); #1;
      end
      check("bp_still_resp", 64'(rsp_valid), 64'd1);
      req_valid = '0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("bp_idle_busy", 64'(busy), 64'd0);
      check("bp_idle_valid", 64'(rsp_valid), 64'd0);
      check("bp_op_count", 64'(op_count), 64'd3);

      // reset mid-EXEC (ptr 0 -> 2, then reset back to 0)
      issue(1, 32'h0000_0005, 32'h0000_0006, 1'b0, "rstx");
      rst = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*32 +: 32] = fa_a[i];
         req_b[i*32 +: 32] = fa_b[i];
      end
      req_cin = 4'b1010;
      #1;
      check("rstx_ready_in_rst", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("rstx_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rstx_busy", 64'(busy), 64'd0);
      check("rstx_rsp_sum", 64'(rsp_sum), 64'd0);
      check("rstx_rsp_id", 64'(rsp_id), 64'd0);
      check("rstx_rsp_cout", 64'(rsp_cout), 64'd0);
      check("rstx_op_count", 64'(op_count), 64'd0);

      // fairness: all valid, rsp_ready held high; grant order 0,1,2,3,0
      rsp_ready = 1'b1;
      for (int op = 0; op < 5; op++) begin
         int e;
         e = op % NREQ;
         check("fair_grant", 64'(req_ready), 64'(1) << e);
         check("fair_onehot", 64'($onehot0(req_ready)), 64'd1);
         @(posedge clk); #1;
         check("fair_exec_ready", 64'(req_ready), 64'd0);
         check("fair_exec_busy", 64'(busy), 64'd1);
         @(posedge clk); #1;
         check("fair_rsp_valid", 64'(rsp_valid), 64'd1);
         check("fair_rsp_id", 64'(rsp_id), 64'(e));
         check("fair_rsp_sum", 64'(rsp_sum), 64'(fa_e[e][31:0]));
         check("fair_rsp_cout", 64'(rsp_cout), 64'(fa_e[e][32]));
         @(posedge clk); #1;
      end
      req_valid = '0;
      rsp_ready = 1'b0;
      #1;
      check("fair_op_count", 64'(op_count), 64'd5);

      // counter wrap: preload 0xFFFF, then one more op (ptr 1, only req 0)
      force dut.op_cnt_q = 16'hFFFF;
      #1;
      release dut.op_cnt_q;
      #1;
      check("wrap_preload", 64'(op_count), 64'hFFFF);
      issue(0, 32'h0000_0000, 32'h0000_0000, 1'b0, "wrap");
      finish_op(32'h0000_0000, 1'b0, 0, 16'h0000, "wrap");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
